// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the decode stage behind it.
package if_id_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // IF/ID pipeline bundle; the ID stage consumes the same layout.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_stage_if.sv
// Bus between the fetch stage (master) and imem / hazard logic / decode (slave).
// Optional IF_ID_PERF_CNT_EN adds the fetch and bubble counter outputs.
interface if_id_stage_if #(
  parameter int IMEM_AW = 8
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               stall;
  logic               flush;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic [31:0]        pc_o;
  logic               id_valid;
  logic [31:0]        id_instr;
  logic [31:0]        id_pc;
  logic [31:0]        id_pc_plus4;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]        fetch_cnt;
  logic [31:0]        bubble_cnt;

  modport master (
    output imem_addr, pc_o, id_valid, id_instr, id_pc, id_pc_plus4, fetch_cnt, bubble_cnt,
    input  imem_rdata, stall, flush, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_addr, pc_o, id_valid, id_instr, id_pc, id_pc_plus4, fetch_cnt, bubble_cnt,
    output imem_rdata, stall, flush, redirect_valid, redirect_pc
  );
`else
  modport master (
    output imem_addr, pc_o, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_rdata, stall, flush, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_addr, pc_o, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_rdata, stall, flush, redirect_valid, redirect_pc
  );
`endif

endinterface

// File: rtl/if_id_stage_pc_reg.sv
// Fetch PC register: +4 sequencing, stall hold, and word-aligned redirect.
module if_id_stage_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc_plus4_o = pc_q + 32'd4;
  assign pc_o       = pc_q;

  // Redirect beats stall; misaligned targets are silently word-aligned.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i & 32'hFFFF_FFFC;
    end else if (!stall_i) begin
      pc_d = pc_plus4_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID register. Optional macro IF_ID_PERF_CNT_EN adds
// fetch/bubble performance counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          IMEM_AW   = 8,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input logic           clk,
  input logic           reset,
  if_id_stage_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pcPlus4;
  if_id_t      ifid_q;
  if_id_t      ifid_d;

  if_id_stage_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i           (clk),
    .rst_i           (reset),
    .stall_i         (bus.stall),
    .redirect_valid_i(bus.redirect_valid),
    .redirect_pc_i   (bus.redirect_pc),
    .pc_o            (pc),
    .pc_plus4_o      (pcPlus4)
  );

  assign bus.imem_addr   = pc[IMEM_AW+1:2];
  assign bus.pc_o        = pc;
  assign bus.id_valid    = ifid_q.valid;
  assign bus.id_instr    = ifid_q.instr;
  assign bus.id_pc       = ifid_q.pc;
  assign bus.id_pc_plus4 = ifid_q.pc_plus4;

  // A bubble keeps the old id_pc/id_pc_plus4; only valid and instr are cleared.
  always_comb begin
    ifid_d = ifid_q;
    if (bus.redirect_valid || bus.flush) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else if (!bus.stall) begin
      ifid_d.valid    = 1'b1;
      ifid_d.instr    = bus.imem_rdata;
      ifid_d.pc       = pc;
      ifid_d.pc_plus4 = pcPlus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_q.valid    <= 1'b0;
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc       <= 32'd0;
      ifid_q.pc_plus4 <= 32'd0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] fetchCnt_q;
  logic [31:0] fetchCnt_d;
  logic [31:0] bubbleCnt_q;
  logic [31:0] bubbleCnt_d;
  logic        loadBubble;
  logic        loadValid;

  assign loadBubble     = bus.redirect_valid || bus.flush;
  assign loadValid      = !loadBubble && !bus.stall;
  assign bus.fetch_cnt  = fetchCnt_q;
  assign bus.bubble_cnt = bubbleCnt_q;

  always_comb begin
    fetchCnt_d  = fetchCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    if (loadValid) begin
      fetchCnt_d = fetchCnt_q + 32'd1;
    end
    if (loadBubble) begin
      bubbleCnt_d = bubbleCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchCnt_q  <= 32'd0;
      bubbleCnt_q <= 32'd0;
    end else begin
      fetchCnt_q  <= fetchCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed scenarios plus random stall/flush/redirect traffic.
module tb_if_id_stage;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] idPc;
    logic [31:0] idPc4;
    logic [31:0] fetch;
    logic [31:0] bubble;
  } expT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem [256];
  expT         expQ [$];
  int          checks = 0;
  int          failures = 0;

  // Reference model: architectural fetch state after each edge
  logic [31:0] mPc, mInstr, mIdPc, mIdPc4, mFetch, mBubble;
  logic        mValid;

  if_id_stage_if #(.IMEM_AW(8)) bus ();

  if_id_stage dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = mem[bus.imem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkCounters(input logic [31:0] expFetch, input logic [31:0] expBubble);
`ifdef IF_ID_PERF_CNT_EN
    checkOutput("fetch_cnt", bus.fetch_cnt, expFetch);
    checkOutput("bubble_cnt", bus.bubble_cnt, expBubble);
`else
    if (expFetch === 32'hx || expBubble === 32'hx) $display("[TB] counter model undefined");
`endif
  endtask

  // Called during the low clock phase; applies one cycle of requests and predicts the edge.
  task automatic applyStimulus(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    expT e;
    bus.stall          = st;
    bus.flush          = fl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (rv) begin
      mValid = 1'b0;
      mInstr = 32'h0;
      mPc    = {rpc[31:2], 2'b00};
      mBubble++;
    end else if (fl) begin
      mValid = 1'b0;
      mInstr = 32'h0;
      if (!st) mPc = mPc + 32'd4;
      mBubble++;
    end else if (!st) begin
      mValid = 1'b1;
      mInstr = mem[mPc[9:2]];
      mIdPc  = mPc;
      mIdPc4 = mPc + 32'd4;
      mPc    = mPc + 32'd4;
      mFetch++;
    end
    e = '{pc: mPc, valid: mValid, instr: mInstr, idPc: mIdPc, idPc4: mIdPc4,
          fetch: mFetch, bubble: mBubble};
    expQ.push_back(e);
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, then releases on a negedge.
  task automatic applyReset();
    #2;
    reset              = 1'b1;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    #1;
    checkOutput("rst_pc", bus.pc_o, 32'h0);
    checkOutput("rst_valid", {31'h0, bus.id_valid}, 32'h0);
    checkOutput("rst_instr", bus.id_instr, 32'h0);
    checkOutput("rst_id_pc", bus.id_pc, 32'h0);
    checkOutput("rst_id_pc4", bus.id_pc_plus4, 32'h0);
    checkCounters(32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    mPc     = 32'h0;
    mValid  = 1'b0;
    mInstr  = 32'h0;
    mIdPc   = 32'h0;
    mIdPc4  = 32'h0;
    mFetch  = 32'h0;
    mBubble = 32'h0;
    #1;
    checkOutput("release_imem_addr", {24'h0, bus.imem_addr}, 32'h0);
    checkOutput("release_valid", {31'h0, bus.id_valid}, 32'h0);
  endtask

  // Monitor: compares every predicted edge just after it happens
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc_o", bus.pc_o, e.pc);
        checkOutput("imem_addr", {24'h0, bus.imem_addr}, {24'h0, e.pc[9:2]});
        checkOutput("id_valid", {31'h0, bus.id_valid}, {31'h0, e.valid});
        checkOutput("id_instr", bus.id_instr, e.instr);
        checkOutput("id_pc", bus.id_pc, e.idPc);
        checkOutput("id_pc_plus4", bus.id_pc_plus4, e.idPc4);
        checkCounters(e.fetch, e.bubble);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h2002_0007;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Basic fetch, stall and redirect-under-stall
    applyReset();
    applyStimulus(0, 0, 0, 0);
    checkOutput("edge1_instr", bus.id_instr, 32'h2001_0005);
    checkOutput("edge1_id_pc", bus.id_pc, 32'h0);
    checkOutput("edge1_id_pc4", bus.id_pc_plus4, 32'h4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("edge2_id_pc", bus.id_pc, 32'h4);
    checkOutput("edge2_pc", bus.pc_o, 32'h8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("stall_pc", bus.pc_o, 32'h8);
      checkOutput("stall_id_pc", bus.id_pc, 32'h4);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("unstall_id_pc", bus.id_pc, 32'h8);
    applyStimulus(1, 0, 1, 32'h0000_0042);
    checkOutput("redir_pc", bus.pc_o, 32'h40);
    checkOutput("redir_valid", {31'h0, bus.id_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("redir_fetch_id_pc", bus.id_pc, 32'h40);
    checkOutput("redir_fetch_instr", bus.id_instr, mem[16]);

    // Flush with and without stall at pc=12
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("flush_stall_pc", bus.pc_o, 32'd12);
    applyStimulus(0, 1, 0, 0);
    checkOutput("flush_pc", bus.pc_o, 32'd16);

    // Counter scenario: 5 fetches, 2 stalls, 1 redirect
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h100);
    checkCounters(32'd5, 32'd1);

    // PC wraps modulo 2^32
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrap_pc", bus.pc_o, 32'h0);
    checkOutput("wrap_id_pc4", bus.id_pc_plus4, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, $urandom);
    end

    // Asynchronous reset while a valid instruction sits in IF/ID
    applyStimulus(0, 0, 0, 0);
    checkOutput("pre_reset_valid", {31'h0, bus.id_valid}, 32'h1);
    applyReset();
    applyStimulus(0, 0, 0, 0);
    checkOutput("post_reset_instr", bus.id_instr, 32'h2001_0005);

    checkOutput("queue_drained", expQ.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
